// File: rtl/psr_flags_if.sv
// psr_flags_if: request/response bundle for the PSR stage.
//   master : pipeline side; drives ALU flags, update mask, LPR load and
//            interrupt save/restore requests, and observes the PSR outputs.
//   slave  : psr_flags side; the mirror image.
interface psr_flags_if #(
    parameter int WIDTH = 16
);
    logic             alu_valid;
    logic [4:0]       flag_we;      // {Z,N,F,L,C}
    logic             alu_c;
    logic             alu_l;
    logic             alu_f;
    logic             alu_n;
    logic             alu_z;
    logic             lpr_we;
    logic [WIDTH-1:0] lpr_data;
    logic             irq_save;
    logic             irq_restore;

    logic [WIDTH-1:0] psr_out;
    logic             C;
    logic             L;
    logic             F;
    logic             N;
    logic             Z;
    logic             ie;
    logic             shadow_valid;
    logic             save_err;
    logic             restore_err;

    modport master (
        output alu_valid, flag_we, alu_c, alu_l, alu_f, alu_n, alu_z,
               lpr_we, lpr_data, irq_save, irq_restore,
        input  psr_out, C, L, F, N, Z, ie, shadow_valid, save_err, restore_err
    );

    modport slave (
        input  alu_valid, flag_we, alu_c, alu_l, alu_f, alu_n, alu_z,
               lpr_we, lpr_data, irq_save, irq_restore,
        output psr_out, C, L, F, N, Z, ie, shadow_valid, save_err, restore_err
    );
endinterface

// File: rtl/psr_flags.sv
// psr_flags: processor status register feeding the condition decoder.
//   clk, rst_n : clock (rising edge), asynchronous active-low reset.
//   bus        : psr_flags_if.slave -- ALU flag update under flag_we mask,
//                whole-word LPR load, single-level interrupt shadow
//                (irq_save / irq_restore); outputs psr_out, C/L/F/N/Z, ie,
//                shadow_valid and one-cycle save_err / restore_err pulses.
// Bit map: C=0, L=2, F=5, Z=6, N=7, E=9; every other bit reads 0.
// Optional: define PSR_FLAG_BYPASS_EN to forward ALU flags combinationally
// onto C/L/F/N/Z for zero-latency compare-then-branch.
module psr_flags #(
    parameter int WIDTH = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    psr_flags_if.slave  bus
);
    localparam int C_BIT = 0;
    localparam int L_BIT = 2;
    localparam int F_BIT = 5;
    localparam int Z_BIT = 6;
    localparam int N_BIT = 7;
    localparam int E_BIT = 9;
    localparam logic [WIDTH-1:0] PSR_MASK = WIDTH'((1 << C_BIT) | (1 << L_BIT) |
        (1 << F_BIT) | (1 << Z_BIT) | (1 << N_BIT) | (1 << E_BIT));

    logic [WIDTH-1:0] psr_q, psr_d;
    logic [WIDTH-1:0] shadow_q, shadow_d;
    logic             shadow_valid_q, shadow_valid_d;
    logic             save_err_q, save_err_d;
    logic             restore_err_q, restore_err_d;

    logic [WIDTH-1:0] psr_nxt;
    logic             restore_ok;
    logic             save_ok;

    always_comb begin
        // A restore only counts when there is something to restore.
        restore_ok = bus.irq_restore && shadow_valid_q;
        save_ok    = bus.irq_save && !shadow_valid_q && !restore_ok;

        psr_nxt = psr_q;
        if (restore_ok) begin
            psr_nxt = shadow_q;
        end else if (bus.lpr_we) begin
            psr_nxt = bus.lpr_data & PSR_MASK;
        end else if (bus.alu_valid) begin
            if (bus.flag_we[0]) psr_nxt[C_BIT] = bus.alu_c;
            if (bus.flag_we[1]) psr_nxt[L_BIT] = bus.alu_l;
            if (bus.flag_we[2]) psr_nxt[F_BIT] = bus.alu_f;
            if (bus.flag_we[3]) psr_nxt[N_BIT] = bus.alu_n;
            if (bus.flag_we[4]) psr_nxt[Z_BIT] = bus.alu_z;
        end

        // Shadow captures the post-update word so a same-cycle ALU/LPR
        // write is not lost; the live copy then has interrupts disabled.
        psr_d          = psr_nxt;
        shadow_d       = shadow_q;
        shadow_valid_d = shadow_valid_q;
        if (save_ok) begin
            shadow_d       = psr_nxt;
            psr_d[E_BIT]   = 1'b0;
            shadow_valid_d = 1'b1;
        end else if (restore_ok) begin
            shadow_valid_d = 1'b0;
        end

        // A save dropped in favour of a restore is not an error.
        save_err_d    = bus.irq_save && shadow_valid_q && !restore_ok;
        restore_err_d = bus.irq_restore && !shadow_valid_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            psr_q          <= '0;
            shadow_q       <= '0;
            shadow_valid_q <= 1'b0;
            save_err_q     <= 1'b0;
            restore_err_q  <= 1'b0;
        end else begin
            psr_q          <= psr_d;
            shadow_q       <= shadow_d;
            shadow_valid_q <= shadow_valid_d;
            save_err_q     <= save_err_d;
            restore_err_q  <= restore_err_d;
        end
    end

    assign bus.psr_out      = psr_q;
    assign bus.ie           = psr_q[E_BIT];
    assign bus.shadow_valid = shadow_valid_q;
    assign bus.save_err     = save_err_q;
    assign bus.restore_err  = restore_err_q;

`ifdef PSR_FLAG_BYPASS_EN
    logic fwd;
    assign fwd   = bus.alu_valid && !restore_ok && !bus.lpr_we;
    assign bus.C = (fwd && bus.flag_we[0]) ? bus.alu_c : psr_q[C_BIT];
    assign bus.L = (fwd && bus.flag_we[1]) ? bus.alu_l : psr_q[L_BIT];
    assign bus.F = (fwd && bus.flag_we[2]) ? bus.alu_f : psr_q[F_BIT];
    assign bus.N = (fwd && bus.flag_we[3]) ? bus.alu_n : psr_q[N_BIT];
    assign bus.Z = (fwd && bus.flag_we[4]) ? bus.alu_z : psr_q[Z_BIT];
`else
    assign bus.C = psr_q[C_BIT];
    assign bus.L = psr_q[L_BIT];
    assign bus.F = psr_q[F_BIT];
    assign bus.N = psr_q[N_BIT];
    assign bus.Z = psr_q[Z_BIT];
`endif

endmodule

// File: tb/tb_psr_flags.sv
module tb_psr_flags;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    psr_flags_if #(.WIDTH(16)) bus ();
    psr_flags #(.WIDTH(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int n_cmp = 0;
    int n_err = 0;

    // reference state
    logic [15:0] m_psr, m_sh;
    logic        m_sv, m_serr, m_rerr;
    logic [4:0]  alu_v;   // {z,n,f,l,c}

    // PSR bit positions of flag_we[0..4] = C,L,F,N,Z
    int pos[5] = '{0, 2, 5, 7, 6};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic av, input logic [4:0] we, input logic [4:0] alu,
                         input logic lw, input logic [15:0] ld, input logic sv, input logic rs);
        alu_v           = alu;
        bus.alu_valid   = av;
        bus.flag_we     = we;
        bus.alu_c       = alu[0];
        bus.alu_l       = alu[1];
        bus.alu_f       = alu[2];
        bus.alu_n       = alu[3];
        bus.alu_z       = alu[4];
        bus.lpr_we      = lw;
        bus.lpr_data    = ld;
        bus.irq_save    = sv;
        bus.irq_restore = rs;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 5'd0, 1'b0, 16'h0, 1'b0, 1'b0);
    endtask

    task automatic model_reset();
        m_psr = 16'h0; m_sh = 16'h0; m_sv = 1'b0; m_serr = 1'b0; m_rerr = 1'b0;
    endtask

    // One clock edge of the architectural rules.
    task automatic model_step();
        logic [15:0] nxt;
        logic rv, sv;
        rv  = bus.irq_restore && m_sv;
        nxt = m_psr;
        if (rv) nxt = m_sh;
        else if (bus.lpr_we) nxt = bus.lpr_data & 16'h02E5;
        else if (bus.alu_valid)
            for (int i = 0; i < 5; i++)
                if (bus.flag_we[i]) nxt[pos[i]] = alu_v[i];
        sv     = bus.irq_save && !m_sv;
        m_serr = bus.irq_save && m_sv && !rv;
        m_rerr = bus.irq_restore && !m_sv;
        if (sv) begin
            m_sh = nxt;
            nxt[9] = 1'b0;
            m_sv = 1'b1;
        end else if (rv) begin
            m_sv = 1'b0;
        end
        m_psr = nxt;
    endtask

    task automatic check_all(input string tag);
        logic [4:0] ef, gf;
        for (int i = 0; i < 5; i++) ef[i] = m_psr[pos[i]];
`ifdef PSR_FLAG_BYPASS_EN
        for (int i = 0; i < 5; i++)
            if (bus.alu_valid && bus.flag_we[i] && !bus.lpr_we && !(bus.irq_restore && m_sv))
                ef[i] = alu_v[i];
`endif
        gf = {bus.Z, bus.N, bus.F, bus.L, bus.C};
        chk({tag, "/psr"},   32'(bus.psr_out),      32'(m_psr));
        chk({tag, "/flags"}, 32'(gf),               32'(ef));
        chk({tag, "/ie"},    32'(bus.ie),           32'(m_psr[9]));
        chk({tag, "/sv"},    32'(bus.shadow_valid), 32'(m_sv));
        chk({tag, "/serr"},  32'(bus.save_err),     32'(m_serr));
        chk({tag, "/rerr"},  32'(bus.restore_err),  32'(m_rerr));
    endtask

    // Apply current inputs for one edge, then check at the falling edge.
    task automatic cycle(input string tag);
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all(tag);
    endtask

    initial begin
        idle();
        model_reset();
        #3;
        check_all("reset");
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 5; i++) begin
            cycle("idle");
            chk("idle_psr0", 32'(bus.psr_out), 32'h0);
        end

        // ALU full update then partial update
        drive(1'b1, 5'b11111, 5'b10101, 1'b0, 16'h0, 1'b0, 1'b0);
        cycle("alu_all");
        chk("alu_all_psr", 32'(bus.psr_out), 32'h0061);
        drive(1'b1, 5'b00001, 5'b00000, 1'b0, 16'h0, 1'b0, 1'b0);
        cycle("alu_c");
        chk("alu_c_psr", 32'(bus.psr_out), 32'h0060);

        // LPR with reserved bits masked, and LPR beating ALU
        drive(1'b0, 5'b00000, 5'b00000, 1'b1, 16'hFFFF, 1'b0, 1'b0);
        cycle("lpr");
        chk("lpr_psr", 32'(bus.psr_out), 32'h02E5);
        drive(1'b1, 5'b11111, 5'b00000, 1'b1, 16'hFFFF, 1'b0, 1'b0);
        cycle("lpr_alu");
        chk("lpr_alu_psr", 32'(bus.psr_out), 32'h02E5);

        // save with same-cycle ALU update, then restore
        drive(1'b0, 5'b00000, 5'b00000, 1'b1, 16'h0200, 1'b0, 1'b0);
        cycle("lpr200");
        drive(1'b1, 5'b01000, 5'b01000, 1'b0, 16'h0, 1'b1, 1'b0);
        cycle("save_alu");
        chk("save_alu_psr", 32'(bus.psr_out), 32'h0080);
        chk("save_alu_sv", 32'(bus.shadow_valid), 32'h1);
        drive(1'b0, 5'b00000, 5'b00000, 1'b0, 16'h0, 1'b0, 1'b1);
        cycle("restore");
        chk("restore_psr", 32'(bus.psr_out), 32'h0280);

        // nested save error, then restore, then empty restore error
        drive(1'b0, 5'b00000, 5'b00000, 1'b0, 16'h0, 1'b1, 1'b0);
        cycle("save1");
        cycle("save2");
        chk("save2_err", 32'(bus.save_err), 32'h1);
        idle();
        cycle("save_err_clr");
        chk("save_err_clr", 32'(bus.save_err), 32'h0);
        drive(1'b0, 5'b00000, 5'b00000, 1'b0, 16'h0, 1'b1, 1'b1);
        cycle("save_restore");
        chk("sr_psr", 32'(bus.psr_out), 32'h0280);
        drive(1'b0, 5'b00000, 5'b00000, 1'b0, 16'h0, 1'b0, 1'b1);
        cycle("restore_empty");
        chk("rerr", 32'(bus.restore_err), 32'h1);
        idle();
        cycle("rerr_clr");

        // async reset mid-cycle after a save
        drive(1'b0, 5'b00000, 5'b00000, 1'b0, 16'h0, 1'b1, 1'b0);
        cycle("save_pre_rst");
        idle();
        @(posedge clk);
        model_step();
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk("async_rst_psr", 32'(bus.psr_out), 32'h0);
        chk("async_rst_sv", 32'(bus.shadow_valid), 32'h0);
        @(negedge clk);
        check_all("in_rst");
        rst_n = 1'b1;

`ifdef PSR_FLAG_BYPASS_EN
        drive(1'b1, 5'b10000, 5'b10000, 1'b0, 16'h0, 1'b0, 1'b0);
        #1;
        chk("bypass_z", 32'(bus.Z), 32'h1);
        cycle("bypass");
`endif

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 1)), 5'($urandom), 5'($urandom),
                  ($urandom_range(0, 4) == 0), 16'($urandom),
                  ($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0));
`ifdef PSR_FLAG_BYPASS_EN
            #1;
            check_all("rnd_comb");
`endif
            cycle("rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
